// File: rtl/fifo_ctrl_pkg.sv
// fifo_ctrl_pkg: grant-select encoding and reset constants shared by the FIFO write controller.
package fifo_ctrl_pkg;
    typedef enum logic {GNT_P0 = 1'b0, GNT_P1 = 1'b1} gnt_sel_e;
    // last_gnt resets to producer 1 so producer 0 wins the first tie
    localparam gnt_sel_e LAST_GNT_RST = GNT_P1;
endpackage

// File: rtl/fifo_wr_arb_ctrl_if.sv
// fifo_wr_arb_ctrl_if: producer, consumer and dp_ram-side signals of the FIFO write controller.
interface fifo_wr_arb_ctrl_if #(
    parameter int WIDTH = 8,
    parameter int SIZE  = 3
);
    logic             req0;
    logic             req1;
    logic [WIDTH-1:0] data0;
    logic [WIDTH-1:0] data1;
    logic             gnt0;
    logic             gnt1;
    logic             rd_req;
    logic             rd_valid;
    logic             ram_wr_en;
    logic [SIZE:0]    ram_wr_addr;
    logic [WIDTH-1:0] ram_data_in;
    logic             ram_rd_en;
    logic [SIZE:0]    ram_rd_addr;
    logic             full;
    logic             empty;
    logic [SIZE:0]    count;
    modport master (
        output req0, req1, data0, data1, rd_req,
        input  gnt0, gnt1, rd_valid, ram_wr_en, ram_wr_addr, ram_data_in,
        input  ram_rd_en, ram_rd_addr, full, empty, count
    );
    modport slave (
        input  req0, req1, data0, data1, rd_req,
        output gnt0, gnt1, rd_valid, ram_wr_en, ram_wr_addr, ram_data_in,
        output ram_rd_en, ram_rd_addr, full, empty, count
    );
endinterface

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin arbiter; on a tie the producer not granted last wins.
module rr_arb2
    import fifo_ctrl_pkg::*;
(
    input  logic     req0,
    input  logic     req1,
    input  logic     block,
    input  gnt_sel_e last_gnt,
    output logic     gnt0,
    output logic     gnt1
);
    // grant the lone requester, or on a tie the one that lost last time
    always_comb begin
        gnt0 = !block && req0 && (!req1 || last_gnt == GNT_P1);
        gnt1 = !block && req1 && (!req0 || last_gnt == GNT_P0);
    end
endmodule

// File: rtl/fifo_wr_arb_ctrl.sv
// fifo_wr_arb_ctrl: dp_ram FIFO pointer/status controller with a two-producer round-robin write port.
// Define FIFO_ARB_ERR_EN to add sticky err_ovf/err_unf outputs.
module fifo_wr_arb_ctrl
    import fifo_ctrl_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8,
    parameter int SIZE  = 3
) (
    input  logic                clk,
    input  logic                rstn,
    fifo_wr_arb_ctrl_if.slave   bus
`ifdef FIFO_ARB_ERR_EN
    ,
    output logic                err_ovf,
    output logic                err_unf
`endif
);
    logic [SIZE:0] wr_ptr;
    logic [SIZE:0] rd_ptr;
    logic [SIZE:0] count;
    gnt_sel_e      last_gnt;
    logic          gnt0;
    logic          gnt1;
    logic          wr_en;
    logic          rd_en;
    logic          full;
    logic          empty;
    logic          rd_valid;

    // requests seen while reset is asserted are never granted
    rr_arb2 u_arb (
        .req0     (bus.req0),
        .req1     (bus.req1),
        .block    (full || !rstn),
        .last_gnt (last_gnt),
        .gnt0     (gnt0),
        .gnt1     (gnt1)
    );

    // status comes from registered pointers only, so nothing falls through
    always_comb begin
        count = wr_ptr - rd_ptr;
        empty = wr_ptr == rd_ptr;
        full  = count == (SIZE+1)'(DEPTH);
        wr_en = gnt0 || gnt1;
        rd_en = rstn && bus.rd_req && !empty;
    end

    assign bus.gnt0        = gnt0;
    assign bus.gnt1        = gnt1;
    assign bus.ram_wr_en   = wr_en;
    assign bus.ram_wr_addr = wr_ptr;
    assign bus.ram_data_in = gnt1 ? bus.data1 : bus.data0;
    assign bus.ram_rd_en   = rd_en;
    assign bus.ram_rd_addr = rd_ptr;
    assign bus.rd_valid    = rd_valid;
    assign bus.full        = full;
    assign bus.empty       = empty;
    assign bus.count       = count;

    // advance pointers on accepted transfers; rd_valid tracks the RAM's registered read
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            last_gnt <= LAST_GNT_RST;
            rd_valid <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (wr_en) last_gnt <= gnt1 ? GNT_P1 : GNT_P0;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            rd_valid <= rd_en;
        end
    end

`ifdef FIFO_ARB_ERR_EN
    // sticky flags for requests arriving against a full or empty FIFO
    always_ff @(posedge clk) begin
        if (!rstn) begin
            err_ovf <= 1'b0;
            err_unf <= 1'b0;
        end else begin
            err_ovf <= err_ovf || ((bus.req0 || bus.req1) && full);
            err_unf <= err_unf || (bus.rd_req && empty);
        end
    end
`endif
endmodule

// File: tb/tb_fifo_wr_arb_ctrl.sv
// tb_fifo_wr_arb_ctrl: directed bench for fifo_wr_arb_ctrl with a behavioural dp_ram stand-in.
module tb_fifo_wr_arb_ctrl;
    logic clk = 1'b0;
    logic rstn;
    logic [7:0] mem [8];
    logic [7:0] ram_q;
    int n_cmp = 0;
    int n_err = 0;
`ifdef FIFO_ARB_ERR_EN
    logic err_ovf;
    logic err_unf;
`endif

    fifo_wr_arb_ctrl_if #(.WIDTH(8), .SIZE(3)) bus ();

    fifo_wr_arb_ctrl #(.DEPTH(8), .WIDTH(8), .SIZE(3)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
`ifdef FIFO_ARB_ERR_EN
        ,
        .err_ovf (err_ovf),
        .err_unf (err_unf)
`endif
    );

    always #5 clk = ~clk;

    // dp_ram stand-in: synchronous write, registered read data
    always @(posedge clk) begin
        if (bus.ram_wr_en) mem[bus.ram_wr_addr[2:0]] <= bus.ram_data_in;
        if (bus.ram_rd_en) ram_q <= mem[bus.ram_rd_addr[2:0]];
    end

    task automatic check(input string tag, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] exp_c [8];
        logic [7:0] exp_b [4];
        exp_c = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'hA0};
        exp_b = '{8'h20, 8'h31, 8'h22, 8'h33};
        rstn = 1'b0;
        bus.req0 = 0; bus.req1 = 0; bus.rd_req = 0;
        bus.data0 = 0; bus.data1 = 0;
        tick;
        tick;
        bus.req0 = 1;
        #1;
        check("rst_gnt0", int'(bus.gnt0), 0);
        check("rst_wr_en", int'(bus.ram_wr_en), 0);
        check("rst_empty", int'(bus.empty), 1);
        check("rst_full", int'(bus.full), 0);
        check("rst_count", int'(bus.count), 0);
        check("rst_rd_valid", int'(bus.rd_valid), 0);
        tick;
        bus.req0 = 0;
        rstn = 1'b1;
        check("rst_no_write", int'(bus.count), 0);
        for (int i = 0; i < 8; i++) begin
            bus.req0 = 1;
            bus.data0 = 8'(16 + i);
            #1;
            check("fill_gnt0", int'(bus.gnt0), 1);
            check("fill_gnt1", int'(bus.gnt1), 0);
            check("fill_addr", int'(bus.ram_wr_addr), i);
            tick;
            check("fill_count", int'(bus.count), i + 1);
            check("fill_empty", int'(bus.empty), 0);
        end
        check("full_set", int'(bus.full), 1);
        #1;
        check("full_no_gnt0", int'(bus.gnt0), 0);
        tick;
        check("full_count_hold", int'(bus.count), 8);
`ifdef FIFO_ARB_ERR_EN
        check("err_ovf_set", int'(err_ovf), 1);
`endif
        bus.req0 = 0;
        bus.req1 = 1;
        bus.data1 = 8'hA0;
        bus.rd_req = 1;
        #1;
        check("fullrw_gnt1", int'(bus.gnt1), 0);
        check("fullrw_rd_en", int'(bus.ram_rd_en), 1);
        tick;
        check("fullrw_rd_valid", int'(bus.rd_valid), 1);
        check("fullrw_data", int'(ram_q), 8'h10);
        check("fullrw_count", int'(bus.count), 7);
        bus.rd_req = 0;
        #1;
        check("refill_gnt1", int'(bus.gnt1), 1);
        tick;
        check("refill_count", int'(bus.count), 8);
        check("refill_full", int'(bus.full), 1);
        bus.req1 = 0;
        for (int i = 0; i < 8; i++) begin
            bus.rd_req = 1;
            tick;
            check("drain_valid", int'(bus.rd_valid), 1);
            check("drain_data", int'(ram_q), int'(exp_c[i]));
        end
        bus.rd_req = 0;
        check("drain_empty", int'(bus.empty), 1);
        check("drain_count", int'(bus.count), 0);
        tick;
        check("drain_valid_low", int'(bus.rd_valid), 0);
`ifdef FIFO_ARB_ERR_EN
        check("err_unf_clear", int'(err_unf), 0);
`endif
        bus.req0 = 1;
        bus.req1 = 1;
        for (int i = 0; i < 4; i++) begin
            bus.data0 = 8'(32 + i);
            bus.data1 = 8'(48 + i);
            #1;
            check("rr_gnt0", int'(bus.gnt0), (i % 2 == 0) ? 1 : 0);
            check("rr_gnt1", int'(bus.gnt1), (i % 2 == 1) ? 1 : 0);
            tick;
            check("rr_count", int'(bus.count), i + 1);
        end
        bus.req0 = 0;
        bus.req1 = 0;
        for (int i = 0; i < 4; i++) begin
            bus.rd_req = 1;
            tick;
            check("rr_data", int'(ram_q), int'(exp_b[i]));
        end
        bus.rd_req = 0;
        bus.req0 = 1;
        bus.data0 = 8'h3F;
        tick;
        for (int k = 0; k < 20; k++) begin
            bus.req0 = 1;
            bus.data0 = 8'(64 + k);
            bus.rd_req = 1;
            #1;
            check("pair_gnt0", int'(bus.gnt0), 1);
            tick;
            check("pair_data", int'(ram_q), (k == 0) ? 8'h3F : 64 + k - 1);
            check("pair_count", int'(bus.count), 1);
            check("pair_full", int'(bus.full), 0);
        end
        bus.req0 = 0;
        check("wrap_wr_addr", int'(bus.ram_wr_addr), 2);
        tick;
        check("wrap_last_data", int'(ram_q), 8'h53);
        bus.rd_req = 0;
        check("wrap_empty", int'(bus.empty), 1);
        for (int i = 0; i < 5; i++) begin
            bus.req0 = 1;
            bus.data0 = 8'(96 + i);
            tick;
        end
        check("mid_count5", int'(bus.count), 5);
        rstn = 1'b0;
        bus.rd_req = 1;
        #1;
        check("mid_rst_gnt0", int'(bus.gnt0), 0);
        check("mid_rst_rd_en", int'(bus.ram_rd_en), 0);
        tick;
        check("mid_rst_count", int'(bus.count), 0);
        check("mid_rst_empty", int'(bus.empty), 1);
        check("mid_rst_rd_valid", int'(bus.rd_valid), 0);
`ifdef FIFO_ARB_ERR_EN
        check("mid_rst_err_ovf", int'(err_ovf), 0);
`endif
        rstn = 1'b1;
        bus.req0 = 0;
        tick;
        check("empty_rd_no_valid", int'(bus.rd_valid), 0);
`ifdef FIFO_ARB_ERR_EN
        check("err_unf_set", int'(err_unf), 1);
        bus.rd_req = 0;
        tick;
        check("err_unf_sticky", int'(err_unf), 1);
`endif
        bus.rd_req = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
